adau1761_cmd_sequencer: RTL and testbench



---
 rtl/adau1761_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_adau1761_cmd_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adau1761_cmd_sequencer.sv
// Command front-end for the ADAU1761 SPI configuration engine.
// Buffers write/read/init commands in a small FIFO. Each command becomes
// exactly one single-cycle strobe to the engine. Completion is detected once
// chip-select has gone low and then stayed high for GAP_CYCLES consecutive
// cycles. A watchdog aborts commands that never complete. Each command gets
// one response, held until the consumer accepts it.
module adau1761_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        spi_write,
    output logic        spi_read,
    output logic        spi_init,
    output logic [15:0] spi_address,
    output logic [7:0]  spi_wdata,
    input  logic        spi_cs,
    input  logic [39:0] spi_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_INIT  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_STROBE, S_WAIT_LOW, S_WAIT_HIGH, S_RESP, S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [1:0]    fifo_op   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          push, pop;
    logic [1:0]    head_op;
    logic [1:0]    op_q;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic          tmo_flag;
    logic          tmo_exp, gap_done;

    // Upper engine shift-register bits carry nothing this block needs.
    logic unused_rdata;
    assign unused_rdata = ^spi_rdata[39:8];

    // Ready depends only on the registered count, so a full FIFO never
    // accepts a push even in a cycle where it also pops.
    assign cmd_ready = (count != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (count != '0);
    assign head_op   = fifo_op[rd_ptr];

    // The watchdog fires on the last permitted wait cycle; a clean completion
    // in that same cycle wins.
    assign tmo_exp  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign gap_done = spi_cs && (gap_cnt == GW'(GAP_CYCLES - 1));

    // FIFO storage: entry payload, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cmd_addr;
            fifo_data[wr_ptr] <= cmd_data;
            fifo_op[wr_ptr]   <= cmd_op;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; reserved ops are popped in IDLE without leaving it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (pop && head_op != OP_RSVD) state_nxt = S_STROBE;
            S_STROBE:    state_nxt = S_WAIT_LOW;
            S_WAIT_LOW:  if (tmo_exp) state_nxt = S_RESP;
                         else if (!spi_cs) state_nxt = S_WAIT_HIGH;
            S_WAIT_HIGH: if (gap_done || tmo_exp) state_nxt = S_RESP;
            S_RESP:      state_nxt = S_HOLD;
            S_HOLD:      if (rsp_ready) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Command latch, completion/watchdog counters and response registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            spi_address <= '0;
            spi_wdata   <= '0;
            op_q        <= OP_WRITE;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            tmo_flag    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop && head_op != OP_RSVD) begin
                        spi_address <= fifo_addr[rd_ptr];
                        spi_wdata   <= fifo_data[rd_ptr];
                        op_q        <= head_op;
                    end
                end
                S_STROBE: begin
                    tmo_cnt  <= '0;
                    gap_cnt  <= '0;
                    tmo_flag <= 1'b0;
                end
                S_WAIT_LOW: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    gap_cnt <= '0;
                    if (tmo_exp) tmo_flag <= 1'b1;
                end
                S_WAIT_HIGH: begin
                    // Any low cycle restarts the gap, absorbing the short
                    // high gaps between init sub-transactions.
                    tmo_cnt <= tmo_cnt + 1'b1;
                    gap_cnt <= spi_cs ? gap_cnt + 1'b1 : '0;
                    if (tmo_exp && !gap_done) tmo_flag <= 1'b1;
                end
                S_RESP: begin
                    rsp_valid   <= 1'b1;
                    rsp_timeout <= tmo_flag;
                    rsp_data    <= (!tmo_flag && op_q == OP_READ) ? spi_rdata[7:0] : 8'h00;
                end
                S_HOLD: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Strobes and busy; strobes are masked by reset so none leaks out in
    // the reset cycle itself.
    always_comb begin
        spi_write = resetn && (state == S_STROBE) && (op_q == OP_WRITE);
        spi_read  = resetn && (state == S_STROBE) && (op_q == OP_READ);
        spi_init  = resetn && (state == S_STROBE) && (op_q == OP_INIT);
        busy      = (count != '0) || (state != S_IDLE);
    end

endmodule

// File: tb/tb_adau1761_cmd_sequencer.sv
// Directed bench for adau1761_cmd_sequencer with a behavioural SPI engine
// model driving chip-select. All inputs change on the falling edge, all
// observations are taken on the falling edge.
module tb_adau1761_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int TMO   = 128;

    logic        clk, resetn;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [7:0]  rsp_data;
    logic        spi_write, spi_read, spi_init, spi_cs;
    logic [15:0] spi_address;
    logic [7:0]  spi_wdata;
    logic [39:0] spi_rdata;

    adau1761_cmd_sequencer #(
        .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .spi_write(spi_write), .spi_read(spi_read), .spi_init(spi_init),
        .spi_address(spi_address), .spi_wdata(spi_wdata),
        .spi_cs(spi_cs), .spi_rdata(spi_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Strobe monitor.
    int          str_cnt = 0, str_cyc = 0, str_kind = 0, multi_hot = 0;
    logic [15:0] str_addr;
    logic [7:0]  str_wdata;
    always @(negedge clk) begin
        if (spi_write || spi_read || spi_init) begin
            str_cnt   <= str_cnt + 1;
            str_cyc   <= cyc;
            str_addr  <= spi_address;
            str_wdata <= spi_wdata;
            str_kind  <= spi_write ? 0 : (spi_read ? 1 : 2);
            if ($countones({spi_write, spi_read, spi_init}) != 1) multi_hot <= multi_hot + 1;
        end
    end

    // Response monitor: records every accepted response.
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        tmo;
        int          cyc;
    } rsp_t;
    rsp_t rq[$];
    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready)
            rq.push_back('{spi_address, rsp_data, rsp_timeout, cyc});
    end

    // SPI engine model: write holds cs low wr_lo cycles, read 3 cycles,
    // init runs 21 transactions of 2 low / 2 high.
    bit         model_en = 1'b1;
    int         wr_lo = 32;
    logic [7:0] rd_byte = 8'h00;
    int         rise_cyc = 0;
    int         m_n, m_lo;
    initial begin
        spi_cs    = 1'b1;
        spi_rdata = '0;
        forever begin
            @(negedge clk);
            if (resetn && model_en && (spi_write || spi_read || spi_init)) begin
                m_n  = spi_init ? 21 : 1;
                m_lo = spi_init ? 2 : (spi_write ? wr_lo : 3);
                if (spi_read) spi_rdata = {32'hDEADBEEF, rd_byte};
                for (int t = 0; t < m_n; t++) begin
                    @(negedge clk);
                    spi_cs = 1'b0;
                    repeat (m_lo) @(negedge clk);
                    spi_cs   = 1'b1;
                    rise_cyc = cyc;
                    if (t < m_n - 1) @(negedge clk);
                end
            end
        end
    end

    int push_cyc = 0;
    task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("push_ready", cmd_ready, 1);
        push_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rq.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_count", rq.size(), n);
    endtask

    task automatic take(output rsp_t r);
        if (rq.size() > 0) r = rq.pop_front();
        else r = '{16'h0, 8'h0, 1'b0, 0};
    endtask

    rsp_t        r;
    int          base, lat, n;
    bit          stable;
    logic [32:0] snap;

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_data}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {spi_write, spi_read, spi_init}, 0);
        chk("rst_spi_regs", {spi_address, spi_wdata}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Single write: strobe two cycles after the handshake, response
        // GAP+1 cycles after cs rises.
        base = str_cnt;
        push(2'b00, 16'h4000, 8'h01);
        wait_rsp(1);
        take(r);
        chk("wr_strobe_lat", str_cyc, push_cyc + 2);
        chk("wr_strobe_cnt", str_cnt - base, 1);
        chk("wr_strobe_kind", str_kind, 0);
        chk("wr_spi_fields", {str_addr, str_wdata}, {16'h4000, 8'h01});
        chk("wr_rsp", {r.addr, r.data, r.tmo}, {16'h4000, 8'h00, 1'b0});
        chk("wr_rsp_lat", r.cyc, rise_cyc + GAP + 1);

        // Read returns the low byte of the engine shift register.
        rd_byte = 8'hA5;
        base = str_cnt;
        push(2'b01, 16'h4015, 8'h00);
        wait_rsp(1);
        take(r);
        chk("rd_strobe_cnt", str_cnt - base, 1);
        chk("rd_strobe_kind", str_kind, 1);
        chk("rd_rsp", {r.addr, r.data, r.tmo}, {16'h4015, 8'hA5, 1'b0});

        // Reserved op is dropped: no strobe, no response, block idles.
        base = str_cnt;
        push(2'b11, 16'h4999, 8'h77);
        repeat (10) @(negedge clk);
        chk("rsvd_no_strobe", str_cnt - base, 0);
        chk("rsvd_no_rsp", rq.size(), 0);
        chk("rsvd_busy", busy, 0);

        // Init: 21 cs transactions with short gaps give one strobe and one
        // response, timed from the final cs rise.
        base = str_cnt;
        push(2'b10, 16'h0000, 8'h00);
        wait_rsp(1);
        take(r);
        chk("init_strobe_cnt", str_cnt - base, 1);
        chk("init_strobe_kind", str_kind, 2);
        chk("init_rsp", {r.data, r.tmo}, 0);
        chk("init_rsp_lat", r.cyc, rise_cyc + GAP + 1);
        repeat (30) @(negedge clk);
        chk("init_single_rsp", rq.size(), 0);

        // FIFO fill while the first command is in flight.
        wr_lo = 8;
        base = str_cnt;
        push(2'b00, 16'h4001, 8'h11);
        n = 0;
        while (str_cnt == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        push(2'b00, 16'h4002, 8'h22);
        push(2'b01, 16'h4003, 8'h00);
        push(2'b00, 16'h4004, 8'h44);
        push(2'b00, 16'h4005, 8'h55);
        chk("fifo_full_ready", cmd_ready, 0);
        chk("fifo_full_busy", busy, 1);
        push(2'b00, 16'h4006, 8'h66);
        wait_rsp(6);
        for (int i = 0; i < 6; i++) begin
            take(r);
            chk("fifo_order", {r.addr, r.data, r.tmo},
                {16'h4001 + 16'(i), (i == 2) ? 8'hA5 : 8'h00, 1'b0});
        end

        // Engine never lowers cs: watchdog response, then normal operation.
        model_en = 1'b0;
        push(2'b01, 16'h4020, 8'h00);
        wait_rsp(1);
        take(r);
        lat = r.cyc - str_cyc;
        chk("tmo_flag", r.tmo, 1);
        chk("tmo_data", r.data, 0);
        chk("tmo_lat_window", (lat >= TMO) && (lat <= TMO + 2), 1);
        model_en = 1'b1;
        push(2'b00, 16'h4021, 8'h5A);
        wait_rsp(1);
        take(r);
        chk("post_tmo_rsp", {r.addr, r.data, r.tmo}, {16'h4021, 8'h00, 1'b0});

        // Back-pressure with queued commands, then reset while holding.
        rsp_ready = 1'b0;
        push(2'b00, 16'h4030, 8'h30);
        push(2'b00, 16'h4031, 8'h31);
        push(2'b00, 16'h4032, 8'h32);
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid", rsp_valid, 1);
        chk("hold_addr", spi_address, 16'h4030);
        snap   = {rsp_valid, rsp_data, rsp_timeout, spi_address, 7'h0};
        base   = str_cnt;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if ({rsp_valid, rsp_data, rsp_timeout, spi_address, 7'h0} !== snap) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        chk("hold_no_strobe", str_cnt - base, 0);
        chk("hold_busy", busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs",
            {cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy,
             spi_write, spi_read, spi_init, spi_address, spi_wdata},
            {1'b1, 38'h0});
        chk("rst_mid_busy", busy, 0);
        rsp_ready = 1'b1;
        resetn    = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_queue_lost", str_cnt - base, 0);
        chk("rst_no_rsp", rq.size(), 0);
        chk("rst_idle_busy", busy, 0);
        chk("strobe_onehot", multi_hot, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
